// File: rtl/alu_arb_pkg.sv
// alu_arbiter shared types: opcodes, FSM states, opcode legality check.
// Optional opcode checking is enabled by ALU_ARB_OPCHK_EN.
package alu_arb_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
// Used by alu_arbiter (ALU_ARB_OPCHK_EN does not affect this block).
module alu_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  int j;

  // Scan from farthest to nearest so the closest valid slot wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    j            = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid[j]) begin
        grant_onehot    = '0;
        grant_onehot[j] = 1'b1;
        grant_idx       = IDX_W'(j);
      end
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NUM_REQ clients.
// Define ALU_ARB_OPCHK_EN to reject illegal opcodes without using the ALU.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]          req_op,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_result,
  output logic                          resp_err,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  output logic [3:0]                    alu_opcode,
  input  logic [DATA_WIDTH-1:0]         alu_result
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t state_q, state_d;

  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      grant_q;
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]    pick_oh;
  logic                  any_valid;
  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic [3:0]            alu_op_q;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [3:0]            sel_op;
  logic                  accept;
  logic                  skip;
  logic                  rsp_err;

  alu_rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant_onehot(pick_oh),
    .grant_idx   (pick_idx),
    .any_valid   (any_valid)
  );

  assign sel_a  = req_a[pick_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b  = req_b[pick_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_op = req_op[pick_idx*4 +: 4];
  assign accept = (state_q == IDLE) && any_valid;

`ifdef ALU_ARB_OPCHK_EN
  logic err_q;

  assign skip    = !is_legal_op(sel_op);
  assign rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= skip;
    end
  end
`else
  assign skip    = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    resp_valid  = '0;
    resp_result = '0;
    resp_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = pick_oh;
        if (any_valid) state_d = skip ? RESP : EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        resp_result         = rsp_err ? '0 : alu_result;
        resp_err            = rsp_err;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake and strobes are silenced for the whole reset window.
    if (rst) begin
      req_ready   = '0;
      resp_valid  = '0;
      resp_result = '0;
      resp_err    = 1'b0;
    end
  end

  assign busy       = !rst && (state_q != IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= pick_idx;
        if (!skip) begin
          alu_a_q  <= sel_a;
          alu_b_q  <= sel_b;
          alu_op_q <= sel_op;
        end
      end
      if (state_q == RESP) begin
        rr_ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a registered ADD/SUB ALU fixture.
// Expectations for illegal opcodes depend on ALU_ARB_OPCHK_EN.
module tb_alu_arbiter;

  localparam int N = 3;
  localparam int W = 8;
`ifdef ALU_ARB_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*4-1:0] req_op;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_result;
  logic           resp_err;
  logic           busy;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [3:0]     alu_opcode;
  logic [W-1:0]   alu_result;

  int tests = 0;
  int fails = 0;

  int           ptr;
  logic [W-1:0] la, lb;
  logic [3:0]   lop;

  alu_arbiter #(
    .DATA_WIDTH(W),
    .NUM_REQ   (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_result(resp_result),
    .resp_err   (resp_err),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  // ALU fixture: registered, one-cycle latency; unknown opcodes give a^b.
  always @(posedge clk) begin
    case (alu_opcode)
      4'b0000: alu_result <= alu_a + alu_b;
      4'b0001: alu_result <= alu_a - alu_b;
      default: alu_result <= alu_a ^ alu_b;
    endcase
  end

  function automatic logic [W-1:0] ref_res(
    input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    if (op == 4'b0000) return a + b;
    if (op == 4'b0001) return a - b;
    return a ^ b;
  endfunction

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] op);
    req_valid[i]     = v;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_op[i*4 +: 4] = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, W'($urandom), W'($urandom), 4'($urandom));
    step();
    step();
    @(negedge clk);
    tests++; if (req_ready !== '0) begin fails++;
      $display("FAIL rst_ready got %b want 0", req_ready); end
    tests++; if (resp_valid !== '0) begin fails++;
      $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    tests++; if (busy !== 1'b0 || resp_err !== 1'b0) begin fails++;
      $display("FAIL rst_busy_err got %b%b want 00", busy, resp_err); end
    tests++; if ({alu_a, alu_b, alu_opcode} !== '0) begin fails++;
      $display("FAIL rst_alu_regs got %h %h %h want 0", alu_a, alu_b, alu_opcode); end
    step();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    tests++; if (req_ready !== '0 || busy !== 1'b0) begin fails++;
      $display("FAIL post_rst_idle got ready %b busy %b want 0 0", req_ready, busy); end
    ptr = 0; la = '0; lb = '0; lop = '0;
  endtask

  task automatic test_single();
    step();
    set_req(0, 1'b1, 8'h12, 8'h05, 4'b0000);
    @(negedge clk);
    tests++; if (req_ready !== 3'b001 || busy !== 1'b0) begin fails++;
      $display("FAIL single_accept got ready %b busy %b want 001 0", req_ready, busy); end
    step();
    req_valid = '0;
    @(negedge clk);
    tests++; if (busy !== 1'b1 || req_ready !== '0 || resp_valid !== '0) begin fails++;
      $display("FAIL single_exec got busy %b ready %b rv %b want 1 000 000",
               busy, req_ready, resp_valid); end
    tests++; if ({alu_a, alu_b, alu_opcode} !== {8'h12, 8'h05, 4'h0}) begin fails++;
      $display("FAIL single_alu_in got %h %h %h want 12 05 0", alu_a, alu_b, alu_opcode); end
    step();
    @(negedge clk);
    tests++; if (resp_valid !== 3'b001 || resp_result !== 8'h17 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_resp got rv %b res %h busy %b want 001 17 1",
               resp_valid, resp_result, busy); end
    step();
    @(negedge clk);
    tests++; if (resp_valid !== '0 || busy !== 1'b0) begin fails++;
      $display("FAIL single_done got rv %b busy %b want 000 0", resp_valid, busy); end
    ptr = 1; la = 8'h12; lb = 8'h05; lop = 4'h0;
  endtask

  task automatic test_wrap();
    int           idx [2] = '{1, 0};
    logic [W-1:0] ca  [2] = '{8'h03, 8'hFF};
    logic [W-1:0] cb  [2] = '{8'h05, 8'h01};
    logic [3:0]   cop [2] = '{4'b0001, 4'b0000};
    logic [W-1:0] cex [2] = '{8'hFE, 8'h00};
    logic [N-1:0] oh;
    for (int c = 0; c < 2; c++) begin
      oh = '0;
      oh[idx[c]] = 1'b1;
      step();
      set_req(idx[c], 1'b1, ca[c], cb[c], cop[c]);
      @(negedge clk);
      tests++; if (req_ready !== oh) begin fails++;
        $display("FAIL wrap_ready[%0d] got %b want %b", c, req_ready, oh); end
      step();
      req_valid = '0;
      step();
      @(negedge clk);
      tests++; if (resp_valid !== oh || resp_result !== cex[c]) begin fails++;
        $display("FAIL wrap_resp[%0d] got rv %b res %h want %b %h",
                 c, resp_valid, resp_result, oh, cex[c]); end
      step();
      la = ca[c]; lb = cb[c]; lop = cop[c];
    end
    ptr = 1;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] oh;
    logic [W-1:0] pa, pb;
    logic [3:0]   pop;
    int           g;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, W'($urandom), W'($urandom), 4'($urandom_range(0, 1)));
    set_req(1, 1'b1, W'($urandom), W'($urandom), 4'($urandom_range(0, 1)));
    for (int k = 0; k < 6; k++) begin
      g = k % 2;
      oh = '0;
      oh[g] = 1'b1;
      @(negedge clk);
      tests++; if (req_ready !== oh || resp_valid !== '0) begin fails++;
        $display("FAIL rr_grant[%0d] got ready %b rv %b want %b 000",
                 k, req_ready, resp_valid, oh); end
      pa = req_a[g*W +: W]; pb = req_b[g*W +: W]; pop = req_op[g*4 +: 4];
      step();
      set_req(g, 1'b1, W'($urandom), W'($urandom), 4'($urandom_range(0, 1)));
      @(negedge clk);
      tests++; if (busy !== 1'b1 || req_ready !== '0 || resp_valid !== '0) begin fails++;
        $display("FAIL rr_exec[%0d] got busy %b ready %b rv %b want 1 000 000",
                 k, busy, req_ready, resp_valid); end
      step();
      @(negedge clk);
      tests++; if (resp_valid !== oh || resp_result !== ref_res(pa, pb, pop)) begin
        fails++;
        $display("FAIL rr_resp[%0d] got rv %b res %h want %b %h",
                 k, resp_valid, resp_result, oh, ref_res(pa, pb, pop)); end
      step();
      la = pa; lb = pb; lop = pop;
    end
    req_valid = '0;
    @(negedge clk);
    tests++; if (resp_valid !== '0 || busy !== 1'b0) begin fails++;
      $display("FAIL rr_end got rv %b busy %b want 000 0", resp_valid, busy); end
    ptr = 2;
  endtask

  task automatic test_reset_mid_exec();
    step();
    set_req(1, 1'b1, 8'h33, 8'h11, 4'b0000);
    @(negedge clk);
    tests++; if (req_ready !== 3'b010) begin fails++;
      $display("FAIL mid_accept got %b want 010", req_ready); end
    step();
    rst = 1'b1;
    set_req(0, 1'b1, 8'h44, 8'h01, 4'b0000);
    set_req(2, 1'b1, 8'h55, 8'h01, 4'b0000);
    @(negedge clk);
    tests++; if (busy !== 1'b0 || req_ready !== '0 || resp_valid !== '0) begin fails++;
      $display("FAIL mid_in_rst got busy %b ready %b rv %b want 0 000 000",
               busy, req_ready, resp_valid); end
    step();
    @(negedge clk);
    tests++; if ({alu_a, alu_b, alu_opcode} !== '0 || resp_valid !== '0) begin fails++;
      $display("FAIL mid_alu_clr got %h %h %h rv %b want 0 0 0 000",
               alu_a, alu_b, alu_opcode, resp_valid); end
    step();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (req_ready !== 3'b001 || resp_valid !== '0) begin fails++;
      $display("FAIL mid_regrant got ready %b rv %b want 001 000", req_ready, resp_valid); end
    #1 req_valid = '0;
    step();
    @(negedge clk);
    tests++; if (busy !== 1'b0 || resp_valid !== '0) begin fails++;
      $display("FAIL mid_quiet got busy %b rv %b want 0 000", busy, resp_valid); end
    ptr = 0; la = '0; lb = '0; lop = '0;
  endtask

  task automatic test_req_during_resp();
    step();
    set_req(0, 1'b1, 8'h40, 8'h02, 4'b0000);
    @(negedge clk);
    tests++; if (req_ready !== 3'b001) begin fails++;
      $display("FAIL dresp_first got %b want 001", req_ready); end
    step();
    req_valid = '0;
    step();
    set_req(1, 1'b1, 8'h09, 8'h04, 4'b0001);
    @(negedge clk);
    tests++; if (req_ready !== '0 || resp_valid !== 3'b001 || resp_result !== 8'h42) begin
      fails++;
      $display("FAIL dresp_resp got ready %b rv %b res %h want 000 001 42",
               req_ready, resp_valid, resp_result); end
    step();
    @(negedge clk);
    tests++; if (req_ready !== 3'b010 || resp_valid !== '0) begin fails++;
      $display("FAIL dresp_next got ready %b rv %b want 010 000", req_ready, resp_valid); end
    step();
    req_valid = '0;
    @(negedge clk);
    tests++; if (busy !== 1'b1 || alu_a !== 8'h09 || alu_opcode !== 4'h1) begin fails++;
      $display("FAIL dresp_exec got busy %b a %h op %h want 1 09 1",
               busy, alu_a, alu_opcode); end
    step();
    @(negedge clk);
    tests++; if (resp_valid !== 3'b010 || resp_result !== 8'h05) begin fails++;
      $display("FAIL dresp_resp2 got rv %b res %h want 010 05", resp_valid, resp_result); end
    step();
    ptr = 2; la = 8'h09; lb = 8'h04; lop = 4'h1;
  endtask

  task automatic test_opchk();
    step();
    set_req(0, 1'b1, 8'h55, 8'h22, 4'b0111);
    @(negedge clk);
    tests++; if (req_ready !== 3'b001) begin fails++;
      $display("FAIL opchk_accept got %b want 001", req_ready); end
    step();
    req_valid = '0;
    @(negedge clk);
`ifdef ALU_ARB_OPCHK_EN
    tests++; if (resp_valid !== 3'b001 || resp_result !== '0 || resp_err !== 1'b1) begin
      fails++;
      $display("FAIL opchk_resp got rv %b res %h err %b want 001 00 1",
               resp_valid, resp_result, resp_err); end
    tests++; if (alu_opcode !== 4'h1 || alu_a !== 8'h09) begin fails++;
      $display("FAIL opchk_alu_hold got op %h a %h want 1 09", alu_opcode, alu_a); end
    step();
`else
    tests++; if (resp_valid !== '0 || alu_opcode !== 4'h7) begin fails++;
      $display("FAIL opchk_exec got rv %b op %h want 000 7", resp_valid, alu_opcode); end
    step();
    @(negedge clk);
    tests++; if (resp_valid !== 3'b001 || resp_err !== 1'b0 || resp_result !== 8'h77) begin
      fails++;
      $display("FAIL opchk_resp got rv %b err %b res %h want 001 0 77",
               resp_valid, resp_err, resp_result); end
    step();
    la = 8'h55; lb = 8'h22; lop = 4'h7;
`endif
    @(negedge clk);
    tests++; if (busy !== 1'b0 || resp_valid !== '0) begin fails++;
      $display("FAIL opchk_idle got busy %b rv %b want 0 000", busy, resp_valid); end
    ptr = 1;
  endtask

  task automatic test_random();
    int           cnt, pg, g;
    int           waited [N];
    logic [N-1:0] ex_rdy, oh;
    logic [W-1:0] pa, pb;
    logic [3:0]   pop;
    logic         perr;
    bit           acc;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr = 0; la = '0; lb = '0; lop = '0;
    cnt = 0; acc = 0; pg = 0; perr = 1'b0; pa = '0; pb = '0; pop = '0;
    for (int i = 0; i < N; i++) waited[i] = 0;
    for (int c = 0; c < 400; c++) begin
      if (acc) req_valid[pg] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && c < 370 && $urandom_range(0, 2) == 0) begin
          set_req(i, 1'b1, W'($urandom), W'($urandom),
                  ($urandom_range(0, 4) == 0) ? 4'($urandom_range(2, 15))
                                              : 4'($urandom_range(0, 1)));
          waited[i] = 0;
        end
      end
      acc = 0;
      @(negedge clk);
      tests++; if ({alu_a, alu_b, alu_opcode} !== {la, lb, lop}) begin fails++;
        $display("FAIL rnd_alu_regs c%0d got %h %h %h want %h %h %h",
                 c, alu_a, alu_b, alu_opcode, la, lb, lop); end
      if (cnt == 0) begin
        g = pick(req_valid, ptr);
        ex_rdy = '0;
        if (g >= 0) ex_rdy[g] = 1'b1;
        tests++; if (req_ready !== ex_rdy || busy !== 1'b0 || resp_valid !== '0) begin
          fails++;
          $display("FAIL rnd_idle c%0d got ready %b busy %b rv %b want %b 0 000",
                   c, req_ready, busy, resp_valid, ex_rdy); end
        if (g >= 0) begin
          tests++; if (waited[g] > N - 1) begin fails++;
            $display("FAIL rnd_fair c%0d req %0d waited %0d ops want <= %0d",
                     c, g, waited[g], N - 1); end
          for (int i = 0; i < N; i++)
            if (i != g && req_valid[i]) waited[i]++;
          pg = g;
          pa = req_a[g*W +: W]; pb = req_b[g*W +: W]; pop = req_op[g*4 +: 4];
          perr = OPCHK && (pop > 4'd1);
          if (!perr) begin la = pa; lb = pb; lop = pop; end
          cnt = perr ? 1 : 2;
          acc = 1;
        end
      end else if (cnt == 2) begin
        tests++; if (busy !== 1'b1 || req_ready !== '0 || resp_valid !== '0) begin fails++;
          $display("FAIL rnd_exec c%0d got busy %b ready %b rv %b want 1 000 000",
                   c, busy, req_ready, resp_valid); end
      end else begin
        oh = '0;
        oh[pg] = 1'b1;
        tests++; if (busy !== 1'b1 || req_ready !== '0 || resp_valid !== oh) begin fails++;
          $display("FAIL rnd_resp_strobe c%0d got busy %b ready %b rv %b want 1 000 %b",
                   c, busy, req_ready, resp_valid, oh); end
        tests++; if (resp_result !== (perr ? '0 : ref_res(pa, pb, pop)) ||
                     resp_err !== perr) begin fails++;
          $display("FAIL rnd_resp_data c%0d got res %h err %b want %h %b", c,
                   resp_result, resp_err, perr ? '0 : ref_res(pa, pb, pop), perr); end
        ptr = (pg + 1) % N;
      end
      step();
      if (!acc && cnt > 0) cnt--;
    end
    req_valid = '0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_reset_mid_exec();
    test_req_during_resp();
    test_opchk();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
